serial_adder: RTL

- Bit-serial N-bit adder; sequential consumer of the team's one-bit half-adder cell.
- Accepts two operands over a val/rdy handshake and adds them LSB-first, one bit per cycle.
- Each bit uses a full adder built from two HA_rtl instances plus an OR; the carry is held in a flop.
- Returns N-bit sum and carry-out over a val/rdy handshake.
- Used where area matters more than latency; sits between operand source and result sink in the datapath.

---
 rtl/serial_adder_pkg.sv | 29 ++
 rtl/HA_rtl.sv | 16 +
 rtl/fa_from_ha.sv | 35 +++
 rtl/serial_adder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and sizing helpers for the bit-serial adder.
//   state_e    : controller states (IDLE, CALC, DONE)
//   cnt_width  : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NBITS_DEFAULT = 32'd8;
    localparam int unsigned CNT_W_DEFAULT = $clog2(NBITS_DEFAULT);

    // Counter width: clog2(n) is enough because the counter only has to reach
    // n-1 before the DONE transition; keep at least one bit for tiny widths.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/HA_rtl.sv
// HA_rtl
// One-bit half-adder cell.
//   a, b : input bits
//   sum  : a xor b
//   cout : a and b
module HA_rtl (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

// File: rtl/fa_from_ha.sv
// fa_from_ha
// Combinational one-bit full adder assembled from two half-adder cells.
//   a, b, cin : input bits
//   sum       : a xor b xor cin
//   cout      : carry out; the two half-adder carries can never both be 1,
//               so a plain OR merges them
module fa_from_ha (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1_s;
    logic c1_s;
    logic c2_s;

    HA_rtl u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s1_s),
        .cout (c1_s)
    );

    HA_rtl u_ha1 (
        .a    (s1_s),
        .b    (cin),
        .sum  (sum),
        .cout (c2_s)
    );

    assign cout = c1_s | c2_s;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: captures two nbits-wide operands over a val/rdy handshake,
// adds them LSB-first one bit per clock through a single full adder, and
// returns the sum and carry-out over a second val/rdy handshake.
//   clk, reset_n       : clock, asynchronous active-low reset
//   in_val/in_rdy      : operand handshake (in_rdy only in IDLE)
//   in_a, in_b         : operands
//   out_val/out_rdy    : result handshake (out_val only in DONE)
//   out_sum, out_cout  : result, forced to 0 outside DONE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned nbits = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_a,
    input  logic [nbits-1:0] in_b,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned      CNT_W    = cnt_width(nbits);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(nbits - 32'd1);

    state_e             state_q,  state_d;
    logic [nbits-1:0]   a_q,      a_d;
    logic [nbits-1:0]   b_q,      b_d;
    logic [nbits-1:0]   sum_q,    sum_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               fa_sum_s;
    logic               fa_cout_s;

    fa_from_ha u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // State, operand/sum shift registers, carry and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                // Operands are only sampled on a real handshake, so values
                // on in_a/in_b at any other time never reach state.
                if (in_val) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // After nbits shifts the first (LSB) sum bit has walked down
                // to bit 0, leaving the result in natural order.
                sum_d   = {fa_sum_s, sum_q[nbits-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout_s;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags and result outputs, decoded from registered state only.
    always_comb begin
        in_rdy   = 1'b0;
        out_val  = 1'b0;
        out_sum  = '0;
        out_cout = 1'b0;
        if (state_q == DONE) begin
            out_val  = 1'b1;
            out_sum  = sum_q;
            out_cout = carry_q;
        end else if (state_q == IDLE) begin
            in_rdy = 1'b1;
        end else begin
            in_rdy = 1'b0;
        end
    end

endmodule
